// File: rtl/ucie_ctl_sb_rx_fsm.sv
// Sideband RX controller: assembles NC-bit RDI sideband phases into a
// 64-bit header plus an optional 64-bit data word, holds the message for the
// CTL layer under a valid/ack handshake and returns one credit per message.
module ucie_ctl_sb_rx_fsm #(
    parameter int NC = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [NC-1:0] i_pl_cfg,
    input  logic          i_pl_cfg_vld,
    output logic          o_lp_cfg_crd,
    output logic [63:0]   o_sb_rx_hdr,
    output logic [63:0]   o_sb_rx_data,
    output logic          o_sb_rx_has_data,
    output logic          o_sb_rx_vld,
    input  logic          i_sb_rx_ack,
    output logic          o_busy,
    output logic          o_err_overflow
);

    localparam int         P       = 64 / NC;
    localparam logic [2:0] PH_LAST = 3'(P - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Opcodes (header bits [4:0]) whose message carries a data word.
    function automatic logic op_has_data(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00011, 5'b00101,
            5'b01001, 5'b01011, 5'b01101,
            5'b10001, 5'b11001, 5'b11011: op_has_data = 1'b1;
            default:                      op_has_data = 1'b0;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  ph_q, ph_d;
    logic [63:0] hdr_q, hdr_d;
    logic [63:0] data_q, data_d;
    logic        has_data_q, has_data_d;
    logic        vld_q, vld_d;
    logic        busy_q, busy_d;
    logic        crd_q, crd_d;
    logic        ovf_q, ovf_d;

    // Next-state, phase capture, and handshake/overflow pulse decode.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        has_data_d = has_data_q;
        crd_d      = 1'b0;
        ovf_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_pl_cfg_vld) begin
                    // Phase 0 starts a fresh message; upper header bits are
                    // filled by the remaining phases.
                    hdr_d      = 64'(i_pl_cfg);
                    data_d     = 64'd0;
                    has_data_d = op_has_data(i_pl_cfg[4:0]);
                    ph_d       = 3'd1;
                    state_d    = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (i_pl_cfg_vld) begin
                    hdr_d[int'(ph_q) * NC +: NC] = i_pl_cfg;
                    if (ph_q == PH_LAST) begin
                        ph_d    = 3'd0;
                        state_d = has_data_q ? ST_DATA : ST_HOLD;
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end else begin
                    ph_d = ph_q;
                end
            end
            ST_DATA: begin
                if (i_pl_cfg_vld) begin
                    data_d[int'(ph_q) * NC +: NC] = i_pl_cfg;
                    if (ph_q == PH_LAST) begin
                        ph_d    = 3'd0;
                        state_d = ST_HOLD;
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end else begin
                    ph_d = ph_q;
                end
            end
            ST_HOLD: begin
                // Buffer is full: any incoming phase is dropped and flagged.
                ovf_d = i_pl_cfg_vld;
                if (i_sb_rx_ack) begin
                    state_d = ST_IDLE;
                    crd_d   = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = 3'd0;
            end
        endcase
        vld_d  = (state_d == ST_HOLD);
        busy_d = (state_d == ST_HDR) || (state_d == ST_DATA);
    end

    // State and output registers; reset drops any partial message without a credit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ph_q       <= 3'd0;
            hdr_q      <= 64'd0;
            data_q     <= 64'd0;
            has_data_q <= 1'b0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            crd_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            has_data_q <= has_data_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            crd_q      <= crd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_lp_cfg_crd     = crd_q;
    assign o_sb_rx_hdr      = hdr_q;
    assign o_sb_rx_data     = data_q;
    assign o_sb_rx_has_data = has_data_q;
    assign o_sb_rx_vld      = vld_q;
    assign o_busy           = busy_q;
    assign o_err_overflow   = ovf_q;

endmodule
